// File: rtl/mistura_colunas_inv.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mistura_colunas_inv: iterative AES InvMixColumns, N columns per cycle,  |
// | registered output behind valid/ready, per-block final-round bypass.     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module mistura_colunas_inv #(
  parameter int COLUNAS_POR_CICLO = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] bloco,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  input  logic         ultima,
  output logic [127:0] saida,
  output logic         saida_valida,
  input  logic         saida_pronta
);

  generate
    if (!(COLUNAS_POR_CICLO == 1 || COLUNAS_POR_CICLO == 2 || COLUNAS_POR_CICLO == 4)) begin : g_param_invalido
      $error("COLUNAS_POR_CICLO must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] PROCESSA  = 2'd1;
  localparam logic [1:0] CONCLUIDO = 2'd2;

  // Column step wraps to 0 for N=4; the mask keeps the column bits that pick a pass.
  localparam logic [1:0] c_PASSO = 2'(COLUNAS_POR_CICLO);
  localparam logic [1:0] c_MASK  = ~(c_PASSO - 2'd1);

  logic [1:0]   r_estado;
  logic [1:0]   r_coluna;
  logic [127:0] r_buf;
  logic [127:0] w_prox;
  logic [31:0]  w_res [COLUNAS_POR_CICLO];
  logic         w_aceita;
  logic         w_libera;
  logic         w_ultimo_passo;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [31:0] col_get(input logic [127:0] b, input logic [1:0] idx);
    logic [31:0] r;
    case (idx)
      2'd0:    r = b[127:96];
      2'd1:    r = b[95:64];
      2'd2:    r = b[63:32];
      default: r = b[31:0];
    endcase
    return r;
  endfunction

  assign entrada_pronta = (r_estado == OCIOSO) | ((r_estado == CONCLUIDO) & saida_pronta);
  assign saida_valida   = (r_estado == CONCLUIDO);
  assign saida          = r_buf;
  assign w_aceita       = entrada_valida & entrada_pronta;
  assign w_libera       = saida_valida & saida_pronta;
  assign w_ultimo_passo = ((r_coluna | ~c_MASK) == 2'b11);

  // Only N transform units; unit k always serves column coluna+k.
  genvar gk, gc;
  generate
    for (gk = 0; gk < COLUNAS_POR_CICLO; gk++) begin : g_unidade
      assign w_res[gk] = inv_col(col_get(r_buf, r_coluna + 2'(gk)));
    end
    for (gc = 0; gc < 4; gc++) begin : g_coluna
      logic w_sel;
      assign w_sel = (((2'(gc) ^ r_coluna) & c_MASK) == 2'b00);
      assign w_prox[127-32*gc -: 32] = w_sel ? w_res[gc % COLUNAS_POR_CICLO]
                                             : r_buf[127-32*gc -: 32];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= OCIOSO;
      r_coluna <= 2'd0;
      r_buf    <= 128'd0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_aceita) begin
            r_buf    <= bloco;
            r_coluna <= 2'd0;
            r_estado <= ultima ? CONCLUIDO : PROCESSA;
          end
        end
        PROCESSA: begin
          r_buf    <= w_prox;
          r_coluna <= r_coluna + c_PASSO;
          if (w_ultimo_passo) r_estado <= CONCLUIDO;
        end
        CONCLUIDO: begin
          // An accept here always coincides with a release.
          if (w_aceita) begin
            r_buf    <= bloco;
            r_coluna <= 2'd0;
            r_estado <= ultima ? CONCLUIDO : PROCESSA;
          end else if (w_libera) begin
            r_estado <= OCIOSO;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

endmodule
`default_nettype wire
